// File: rtl/rv_seq_pkg.sv
// Shared types for the RV32I multi-cycle sequencer.
// States, PC/writeback select encodings and address select constants.
package rv_seq_pkg;

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } seq_state_e;

    typedef enum logic [1:0] {
        PC_PLUS4,
        PC_BR,
        PC_JAL,
        PC_JALR
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_PC4,
        WB_LOAD
    } wb_sel_e;

    localparam logic ADDR_PC  = 1'b0;
    localparam logic ADDR_ALU = 1'b1;

endpackage

// File: rtl/rv_mem_wdog.sv
// Memory wait watchdog: counts consecutive stalled request cycles.
// Only instantiated when SEQ_TIMEOUT_EN is defined.
module rv_mem_wdog #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic timeout
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    assign timeout = run && (cnt == CW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!run || timeout) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rv_mc_sequencer.sv
// Multi-cycle control FSM for the RV32I datapath and shared memory port.
// Define SEQ_TIMEOUT_EN to enable the memory wait timeout and bus_err.
module rv_mc_sequencer
    import rv_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 isALUreg,
    input  logic                 isALUimm,
    input  logic                 isLUI,
    input  logic                 isAUIPC,
    input  logic                 isJAL,
    input  logic                 isJALR,
    input  logic                 isBranch,
    input  logic                 isLoad,
    input  logic                 isStore,
    input  logic                 isSYSTEM,
    input  logic                 take_branch,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 addr_sel,
    output logic                 ir_we,
    output logic                 reg_we,
    output logic [1:0]           wb_sel,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 halted,
    output logic                 bus_err,
    output logic [INSTRET_W-1:0] instret
);

    if (MEM_TIMEOUT < 1) begin : g_bad_timeout
        $error("MEM_TIMEOUT must be at least 1");
    end

    seq_state_e state, state_nx;
    pc_sel_e    pc_sel_c;
    wb_sel_e    wb_sel_c;
    logic       retire;
    logic       timeout;

`ifdef SEQ_TIMEOUT_EN
    rv_mem_wdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .run    (mem_req && !mem_ready),
        .timeout(timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_err <= 1'b0;
        end else if (timeout) begin
            bus_err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    assign wb_sel = wb_sel_c;
    assign pc_sel = pc_sel_c;
    assign halted = (state == S_HALT);

    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = ADDR_PC;
        ir_we    = 1'b0;
        reg_we   = 1'b0;
        wb_sel_c = WB_ALU;
        pc_we    = 1'b0;
        pc_sel_c = PC_PLUS4;
        retire   = 1'b0;
        unique case (state)
            S_BOOT: state_nx = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (timeout) begin
                    state_nx = S_HALT;
                end else if (mem_ready) begin
                    ir_we    = 1'b1;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: state_nx = S_EXEC;
            S_EXEC: begin
                unique case (1'b1)
                    isLoad, isStore: state_nx = S_MEM;
                    isSYSTEM:        state_nx = S_HALT;
                    default: begin
                        pc_we    = 1'b1;
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                        reg_we   = isALUreg | isALUimm | isLUI
                                 | isAUIPC | isJAL | isJALR;
                        if (isJAL || isJALR) wb_sel_c = WB_PC4;
                        if (isJAL)
                            pc_sel_c = PC_JAL;
                        else if (isJALR)
                            pc_sel_c = PC_JALR;
                        else if (isBranch && take_branch)
                            pc_sel_c = PC_BR;
                    end
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = ADDR_ALU;
                mem_we   = isStore;
                if (timeout) begin
                    state_nx = S_HALT;
                end else if (mem_ready) begin
                    if (isStore) begin
                        pc_we    = 1'b1;
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we   = 1'b1;
                wb_sel_c = WB_LOAD;
                pc_we    = 1'b1;
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            default: state_nx = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_BOOT;
            instret <= '0;
        end else begin
            state <= state_nx;
            if (retire) instret <= instret + 1'b1;
        end
    end

endmodule

// File: tb/tb_rv_mc_sequencer.sv
// Directed bench for rv_mc_sequencer with hand-computed expectations.
// Covers both SEQ_TIMEOUT_EN builds in the timeout section.
module tb_rv_mc_sequencer;

    localparam int OP_NONE   = 0;
    localparam int OP_ALUIMM = 1;
    localparam int OP_BR     = 2;
    localparam int OP_JAL    = 3;
    localparam int OP_JALR   = 4;
    localparam int OP_LOAD   = 5;
    localparam int OP_STORE  = 6;
    localparam int OP_SYS    = 7;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic isALUreg = 1'b0, isALUimm = 1'b0, isLUI = 1'b0;
    logic isAUIPC = 1'b0, isJAL = 1'b0, isJALR = 1'b0;
    logic isBranch = 1'b0, isLoad = 1'b0, isStore = 1'b0;
    logic isSYSTEM = 1'b0;
    logic take_branch = 1'b0;
    logic mem_ready = 1'b1;
    logic mem_req, mem_we, addr_sel, ir_we, reg_we, pc_we;
    logic halted, bus_err;
    logic [1:0] wb_sel, pc_sel;
    logic [31:0] instret;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv_mc_sequencer #(
        .MEM_TIMEOUT(16),
        .INSTRET_W  (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .isALUreg   (isALUreg),
        .isALUimm   (isALUimm),
        .isLUI      (isLUI),
        .isAUIPC    (isAUIPC),
        .isJAL      (isJAL),
        .isJALR     (isJALR),
        .isBranch   (isBranch),
        .isLoad     (isLoad),
        .isStore    (isStore),
        .isSYSTEM   (isSYSTEM),
        .take_branch(take_branch),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .addr_sel   (addr_sel),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .wb_sel     (wb_sel),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .halted     (halted),
        .bus_err    (bus_err),
        .instret    (instret)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int op);
        isALUreg = 1'b0; isALUimm = 1'b0; isLUI = 1'b0;
        isAUIPC = 1'b0; isJAL = 1'b0; isJALR = 1'b0;
        isBranch = 1'b0; isLoad = 1'b0; isStore = 1'b0;
        isSYSTEM = 1'b0;
        case (op)
            OP_ALUIMM: isALUimm = 1'b1;
            OP_BR:     isBranch = 1'b1;
            OP_JAL:    isJAL = 1'b1;
            OP_JALR:   isJALR = 1'b1;
            OP_LOAD:   isLoad = 1'b1;
            OP_STORE:  isStore = 1'b1;
            OP_SYS:    isSYSTEM = 1'b1;
            default:   ;
        endcase
        #1;
    endtask

    // Called mid-cycle in FETCH with mem_ready=1; returns mid-cycle in EXEC.
    task automatic to_exec(input int op);
        set_op(op);
        chk("fetch_ir_we", 32'(ir_we), 1);
        cyc();
        chk("dec_quiet", 32'({mem_req, ir_we, reg_we, pc_we}), 0);
        cyc();
    endtask

    task automatic exec_jump(input string tag, input int op,
                             input logic tb, input logic [1:0] psel,
                             input logic rwe, input logic [1:0] wsel);
        take_branch = tb;
        to_exec(op);
        chk({tag, "_pc_we"}, 32'(pc_we), 1);
        chk({tag, "_pc_sel"}, 32'(pc_sel), 32'(psel));
        chk({tag, "_reg_we"}, 32'(reg_we), 32'(rwe));
        if (rwe) chk({tag, "_wb_sel"}, 32'(wb_sel), 32'(wsel));
        cyc();
        take_branch = 1'b0;
    endtask

    initial begin
        // reset held 3 cycles
        set_op(OP_NONE);
        reset = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_mem_req", 32'(mem_req), 0);
        end
        chk("rst_instret", instret, 0);
        chk("rst_strobes", 32'({ir_we, reg_we, pc_we, halted, bus_err}), 0);
        reset = 1'b1;
        #1;
        chk("boot_mem_req", 32'(mem_req), 0);
        cyc();
        chk("fetch_mem_req", 32'(mem_req), 1);
        chk("fetch_addr_sel", 32'(addr_sel), 0);
        chk("fetch_mem_we", 32'(mem_we), 0);

        // ADDI
        to_exec(OP_ALUIMM);
        chk("addi_reg_we", 32'(reg_we), 1);
        chk("addi_wb_sel", 32'(wb_sel), 0);
        chk("addi_pc_we", 32'(pc_we), 1);
        chk("addi_pc_sel", 32'(pc_sel), 0);
        chk("addi_instret0", instret, 0);
        cyc();
        chk("addi_instret1", instret, 1);

        // branches and jumps
        exec_jump("beq_t", OP_BR, 1'b1, 2'd1, 1'b0, 2'd0);
        exec_jump("beq_n", OP_BR, 1'b0, 2'd0, 1'b0, 2'd0);
        exec_jump("jalr", OP_JALR, 1'b0, 2'd3, 1'b1, 2'd1);
        exec_jump("jal", OP_JAL, 1'b1, 2'd2, 1'b1, 2'd1);
        chk("jump_instret", instret, 5);

        // LW with 3 wait cycles
        to_exec(OP_LOAD);
        mem_ready = 1'b0;
        #1;
        chk("lw_exec_quiet", 32'({mem_req, reg_we, pc_we}), 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            chk("lw_mem_req", 32'(mem_req), 1);
            chk("lw_addr_sel", 32'(addr_sel), 1);
            chk("lw_mem_we", 32'(mem_we), 0);
            chk("lw_mem_quiet", 32'({reg_we, pc_we, ir_we}), 0);
            cyc();
        end
        chk("lw_wb_reg_we", 32'(reg_we), 1);
        chk("lw_wb_sel", 32'(wb_sel), 2);
        chk("lw_wb_pc", 32'({pc_we, pc_sel}), 32'(3'b100));
        chk("lw_wb_mem_req", 32'(mem_req), 0);
        cyc();
        chk("lw_instret", instret, 6);

        // SW with zero wait
        to_exec(OP_STORE);
        cyc();
        chk("sw_mem_we", 32'({mem_req, mem_we, addr_sel}), 32'(3'b111));
        chk("sw_reg_we", 32'(reg_we), 0);
        chk("sw_pc", 32'({pc_we, pc_sel}), 32'(3'b100));
        cyc();
        chk("sw_instret", instret, 7);

        // reset during a stalled fetch
        mem_ready = 1'b0;
        cyc();
        chk("stall_mem_req", 32'(mem_req), 1);
        chk("stall_ir_we", 32'(ir_we), 0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_mem_req", 32'(mem_req), 0);
        chk("arst_instret", instret, 0);
        mem_ready = 1'b1;
        cyc();
        reset = 1'b1;
        cyc();
        chk("rearm_fetch", 32'(mem_req), 1);

        // EBREAK
        to_exec(OP_SYS);
        chk("sys_quiet", 32'({pc_we, reg_we, mem_req, halted}), 0);
        cyc();
        chk("sys_halted", 32'(halted), 1);
        set_op(OP_ALUIMM);
        cyc();
        cyc();
        chk("halt_still", 32'(halted), 1);
        chk("halt_quiet", 32'({mem_req, ir_we, reg_we, pc_we}), 0);
        chk("halt_instret", instret, 0);

        // memory timeout
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        mem_ready = 1'b0;
        set_op(OP_NONE);
        cyc();
        for (int i = 0; i < 16; i++) begin
            chk("to_waiting", 32'({mem_req, halted}), 32'(2'b10));
            cyc();
        end
`ifdef SEQ_TIMEOUT_EN
        chk("to_bus_err", 32'(bus_err), 1);
        chk("to_halted", 32'(halted), 1);
        chk("to_mem_req", 32'(mem_req), 0);
        mem_ready = 1'b1;
        cyc();
        cyc();
        chk("to_sticky", 32'({bus_err, halted}), 32'(2'b11));
`else
        for (int i = 16; i < 100; i++) cyc();
        chk("nto_mem_req", 32'(mem_req), 1);
        chk("nto_halted", 32'(halted), 0);
        chk("nto_bus_err", 32'(bus_err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
